// File: rtl/conv_ctrl.sv
// Stage sequencer for the convolution core: walks tiles x channels and drives the
// one-hot-per-stage `state` enables, with s2p enables trailing the SRAM reads by RD_LAT.
module conv_ctrl #(
    parameter int IFM_WORDS = 4,
    parameter int WHT_WORDS = 2,
    parameter int RD_LAT    = 1,
    parameter int PE_CYC    = 1,
    parameter int P2S_WORDS = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ctrl,
    output logic [31:0] state,
    output logic        busy,
    output logic        done
);
    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_RIFM, S_RWHT, S_WAIT, S_PE, S_PA,
        S_BA, S_CA, S_RELU, S_P2SW, S_P2SR, S_DONE
    } fsm_t;

    fsm_t        fsm, fsm_nxt;
    logic [7:0]  cyc, cyc_nxt;
    logic [7:0]  num_chnl, num_chnl_nxt, chnl_cnt, chnl_cnt_nxt;
    logic [15:0] num_tiles, num_tiles_nxt, tile_cnt, tile_cnt_nxt;
    logic [31:0] en_q, en_nxt;
    logic        busy_nxt, done_nxt;
    logic [RD_LAT-1:0] ifm_dly, wht_dly;
    logic        ctrl_unused;

    assign ctrl_unused = ^ctrl[7:1];

    // Multi-cycle states share one dwell counter; it returns to 0 on every exit.
    function automatic logic at_end(input logic [7:0] c, input int len);
        return c == 8'(len - 1);
    endfunction

    always_comb begin
        fsm_nxt       = fsm;
        cyc_nxt       = cyc;
        num_chnl_nxt  = num_chnl;
        num_tiles_nxt = num_tiles;
        chnl_cnt_nxt  = chnl_cnt;
        tile_cnt_nxt  = tile_cnt;
        case (fsm)
            S_IDLE: if (ctrl[0]) begin
                num_chnl_nxt  = ctrl[15:8];
                num_tiles_nxt = ctrl[31:16];
                chnl_cnt_nxt  = '0;
                tile_cnt_nxt  = '0;
                cyc_nxt       = '0;
                fsm_nxt = (ctrl[15:8] == 8'd0 || ctrl[31:16] == 16'd0) ? S_DONE : S_CLR;
            end
            S_CLR:  fsm_nxt = S_RIFM;
            S_RIFM: if (at_end(cyc, IFM_WORDS)) begin cyc_nxt = '0; fsm_nxt = S_RWHT; end
                    else cyc_nxt = cyc + 8'd1;
            S_RWHT: if (at_end(cyc, WHT_WORDS)) begin cyc_nxt = '0; fsm_nxt = S_WAIT; end
                    else cyc_nxt = cyc + 8'd1;
            S_WAIT: if (at_end(cyc, RD_LAT)) begin cyc_nxt = '0; fsm_nxt = S_PE; end
                    else cyc_nxt = cyc + 8'd1;
            S_PE:   if (at_end(cyc, PE_CYC)) begin cyc_nxt = '0; fsm_nxt = S_PA; end
                    else cyc_nxt = cyc + 8'd1;
            S_PA:   fsm_nxt = S_BA;
            S_BA:   fsm_nxt = S_CA;
            S_CA:   if (chnl_cnt == num_chnl - 8'd1) fsm_nxt = S_RELU;
                    else begin chnl_cnt_nxt = chnl_cnt + 8'd1; fsm_nxt = S_RIFM; end
            S_RELU: fsm_nxt = S_P2SW;
            S_P2SW: fsm_nxt = S_P2SR;
            S_P2SR: if (at_end(cyc, P2S_WORDS)) begin
                cyc_nxt = '0;
                if (tile_cnt == num_tiles - 16'd1) fsm_nxt = S_DONE;
                else begin
                    tile_cnt_nxt = tile_cnt + 16'd1;
                    chnl_cnt_nxt = '0;
                    fsm_nxt      = S_CLR;
                end
            end else cyc_nxt = cyc + 8'd1;
            S_DONE: fsm_nxt = S_IDLE;
            default: fsm_nxt = S_IDLE;
        endcase

        // Enables are decoded from the next state so they register alongside it.
        en_nxt = '0;
        case (fsm_nxt)
            S_CLR:  en_nxt[13]  = 1'b1;
            S_RIFM: en_nxt[0]   = 1'b1;
            S_RWHT: en_nxt[1]   = 1'b1;
            S_PE:   en_nxt[3:2] = 2'b11;
            S_PA:   en_nxt[7:6] = 2'b11;
            S_BA:   en_nxt[8]   = 1'b1;
            S_CA:   en_nxt[9]   = 1'b1;
            S_RELU: en_nxt[10]  = 1'b1;
            S_P2SW: en_nxt[11]  = 1'b1;
            S_P2SR: en_nxt[12]  = 1'b1;
            default: en_nxt = '0;
        endcase
        busy_nxt = (fsm_nxt != S_IDLE);
        done_nxt = (fsm_nxt == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= S_IDLE;
            cyc       <= '0;
            num_chnl  <= '0;
            num_tiles <= '0;
            chnl_cnt  <= '0;
            tile_cnt  <= '0;
            en_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ifm_dly   <= '0;
            wht_dly   <= '0;
        end else begin
            fsm       <= fsm_nxt;
            cyc       <= cyc_nxt;
            num_chnl  <= num_chnl_nxt;
            num_tiles <= num_tiles_nxt;
            chnl_cnt  <= chnl_cnt_nxt;
            tile_cnt  <= tile_cnt_nxt;
            en_q      <= en_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            ifm_dly[0] <= en_q[0];
            wht_dly[0] <= en_q[1];
            for (int i = 1; i < RD_LAT; i++) begin
                ifm_dly[i] <= ifm_dly[i-1];
                wht_dly[i] <= wht_dly[i-1];
            end
        end
    end

    assign state = en_q | {26'd0, wht_dly[RD_LAT-1], ifm_dly[RD_LAT-1], 4'd0};

endmodule

// File: tb/tb_conv_ctrl.sv
// Random-command bench for conv_ctrl: two instances (RD_LAT 1 and 3) run in lockstep and are
// checked cycle by cycle against a stage timeline built from segment lengths.
module tb_conv_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ctrl;
    logic [31:0] state1, state3;
    logic        busy1, busy3, done1, done3;

    int n_chk = 0;
    int n_bad = 0;

    conv_ctrl #(.RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .ctrl(ctrl),
                                  .state(state1), .busy(busy1), .done(done1));
    conv_ctrl #(.RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .ctrl(ctrl),
                                  .state(state3), .busy(busy3), .done(done3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Timeline entries {done, busy, state}, one per cycle starting the cycle after start.
    logic [33:0] mq [$];
    logic [33:0] e1 [$];
    logic [33:0] e3 [$];

    function automatic void seg(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) mq.push_back({2'b01, v});
    endfunction

    function automatic void build(input int t, input int c, input int lat);
        mq.delete();
        if (t == 0 || c == 0) begin
            mq.push_back({2'b11, 32'd0});
            return;
        end
        for (int ti = 0; ti < t; ti++) begin
            seg(32'h2000, 1);
            for (int ch = 0; ch < c; ch++) begin
                seg(32'h0001, 4);
                seg(32'h0002, 2);
                seg(32'h0000, lat);
                seg(32'h000C, 1);
                seg(32'h00C0, 1);
                seg(32'h0100, 1);
                seg(32'h0200, 1);
            end
            seg(32'h0400, 1);
            seg(32'h0800, 1);
            seg(32'h1000, 9);
        end
        mq.push_back({2'b11, 32'd0});
        // capture enables echo the read enables lat cycles later
        for (int k = mq.size() - 1; k >= lat; k--) begin
            if (mq[k-lat][0]) mq[k][4] = 1'b1;
            if (mq[k-lat][1]) mq[k][5] = 1'b1;
        end
    endfunction

    task automatic run(input int t, input int c, input bit garble, input int abort);
        int n, nmin;
        build(t, c, 1); e1 = mq;
        build(t, c, 3); e3 = mq;
        n    = (e1.size() > e3.size()) ? e1.size() : e3.size();
        nmin = (e1.size() < e3.size()) ? e1.size() : e3.size();
        @(negedge clk);
        ctrl = {t[15:0], c[7:0], 8'h01};
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            ctrl = (garble && k < nmin - 2) ? ($urandom | 32'h1) : 32'h0;
            chk($sformatf("lat1 t%0d c%0d cyc%0d", t, c, k + 1), {done1, busy1, state1},
                (k < e1.size()) ? e1[k] : 34'd0);
            chk($sformatf("lat3 t%0d c%0d cyc%0d", t, c, k + 1), {done3, busy3, state3},
                (k < e3.size()) ? e3[k] : 34'd0);
            if (k == abort) begin
                ctrl = 32'h0;
                rst  = 1'b1;
                @(negedge clk);
                rst  = 1'b0;
                chk("abort lat1", {done1, busy1, state1}, 34'd0);
                chk("abort lat3", {done3, busy3, state3}, 34'd0);
                repeat (3) begin
                    @(negedge clk);
                    chk("post-abort lat1", {done1, busy1, state1}, 34'd0);
                    chk("post-abort lat3", {done3, busy3, state3}, 34'd0);
                end
                return;
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        ctrl = 32'h0001_0101;
        repeat (3) @(negedge clk);
        chk("reset lat1", {done1, busy1, state1}, 34'd0);
        chk("reset lat3", {done3, busy3, state3}, 34'd0);
        rst  = 1'b0;
        ctrl = 32'h0;
        @(negedge clk);
        chk("idle after reset", {done1, busy1, state1}, 34'd0);

        run(1, 1, 1'b0, -1);
        run(1, 3, 1'b0, -1);
        run(2, 1, 1'b0, -1);
        run(0, 2, 1'b0, -1);
        run(3, 0, 1'b0, -1);
        run(1, 1, 1'b1, -1);
        run(1, 3, 1'b0, 8);
        run(1, 1, 1'b0, -1);
        for (int r = 0; r < 14; r++) begin
            int t, c;
            t = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            c = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            run(t, c, 1'(($urandom_range(0, 1))), ($urandom_range(0, 4) == 0) ? $urandom_range(2, 30) : -1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
